mem_stage: RTL and testbench

Memory-access and writeback-formatting stage, downstream of the ALU in the single-issue datapath. Accepts one executed instruction per handshake, performs loads and stores against a data memory over a request/grant/response interface with variable latency, and produces a registered writeback packet for the register file. Stalls upstream through `in_ready_o` while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access and writeback-formatting stage that sits after the ALU in the
// single-issue datapath. It accepts one executed instruction per handshake,
// performs byte, halfword and word loads and stores against a data memory
// with variable latency, and produces a registered writeback packet for the
// register file. Upstream is stalled (in_ready_o low) while a memory
// transaction is outstanding.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid_i/in_ready_o  upstream handshake (ready == FSM in IDLE)
//   pc_i, alu_res_i     instruction PC; ALU result (byte address for mem ops)
//   rs2data_i           store data
//   rd_i, funct3_i      destination register; access size/sign
//   memren_i, memwren_i load / store (both set is treated as a store)
//   regwren_i, wbsel_i  register write enable; writeback source select
//   dmem_*              request/grant/response data-memory port
//   wb_*                registered writeback packet, wb_valid_o pulses once
//   misalign_o          misaligned-access pulse (trap build only)
//
// Configuration
//   MEM_STAGE_MISALIGN_TRAP_EN  when defined, misaligned halfword/word
//   accesses issue no memory request and retire immediately with
//   wb_regwren_o = 0 and a misalign_o pulse. When undefined the low address
//   bits that do not fit the access size are ignored.
//
// Only DWIDTH = 32 is supported; the lane logic assumes four byte lanes.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    input  logic [4:0]        rd_i,
    input  logic [2:0]        funct3_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic              regwren_i,
    input  logic [1:0]        wbsel_i,

    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,

    output logic              wb_valid_o,
    output logic              wb_regwren_o,
    output logic [4:0]        wb_rd_o,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic [AWIDTH-1:0] wb_pc_o
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;

    // Holding registers for the instruction in flight.
    logic [AWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] alu_q;
    logic [4:0]        rd_q;
    logic [2:0]        funct3_q;
    logic              store_q;
    logic              regwren_q;
    logic [1:0]        wbsel_q;

    // funct3[1:0]: 00 byte, 01 halfword, 1x word. funct3[2] selects zero-extend.
    function automatic logic [3:0] byte_en(input logic [2:0] f3,
                                           input logic [1:0] a,
                                           input logic       store);
        if (!store) begin
            return 4'b1111;
        end
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] store_lanes(input logic [2:0]        f3,
                                                      input logic [DWIDTH-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] load_format(input logic [2:0]        f3,
                                                      input logic [1:0]        a,
                                                      input logic [DWIDTH-1:0] w);
        logic [DWIDTH-1:0] shifted;
        logic [7:0]        b;
        logic [15:0]       h;
        shifted = w >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;  // LW, and funct3 3/6/7 load as LW
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] wb_value(input logic [1:0]        sel,
                                                   input logic [DWIDTH-1:0] alu,
                                                   input logic [DWIDTH-1:0] ld,
                                                   input logic [AWIDTH-1:0] pc);
        logic [AWIDTH-1:0] pc4;
        pc4 = pc + AWIDTH'(4);  // wraps mod 2^AWIDTH
        case (sel)
            2'd1:    return ld;
            2'd2:    return DWIDTH'(pc4);
            default: return alu;
        endcase
    endfunction

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction
`endif

    logic mem_op;
    assign mem_op     = memren_i | memwren_i;
    assign in_ready_o = (state == IDLE);

    // NOTE: every register here, including the holding registers, is cleared
    // by rst so an abandoned transaction leaves nothing behind; it is a small
    // register set, not a memory array, so the reset costs nothing notable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc_q         <= '0;
            alu_q        <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            store_q      <= 1'b0;
            regwren_q    <= 1'b0;
            wbsel_q      <= '0;
            dmem_req_o   <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_regwren_o <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            wb_pc_o      <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; the default below
            // makes wb_valid_o a one-cycle pulse that any completion branch
            // later in this block overrides.
            wb_valid_o <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        pc_q      <= pc_i;
                        alu_q     <= alu_res_i;
                        rd_q      <= rd_i;
                        funct3_q  <= funct3_i;
                        store_q   <= memwren_i;
                        regwren_q <= regwren_i;
                        wbsel_q   <= wbsel_i;
                        if (!mem_op) begin
                            wb_valid_o   <= 1'b1;
                            wb_regwren_o <= regwren_i & (rd_i != 5'd0);
                            wb_rd_o      <= rd_i;
                            wb_data_o    <= wb_value(wbsel_i, alu_res_i, '0, pc_i);
                            wb_pc_o      <= pc_i;
                        end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        else if (misaligned(funct3_i, alu_res_i[1:0])) begin
                            wb_valid_o   <= 1'b1;
                            wb_regwren_o <= 1'b0;
                            wb_rd_o      <= rd_i;
                            wb_data_o    <= wb_value(wbsel_i, alu_res_i, '0, pc_i);
                            wb_pc_o      <= pc_i;
                            misalign_o   <= 1'b1;
                        end
`endif
                        else begin
                            state        <= REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_addr_o  <= {alu_res_i[AWIDTH-1:2], 2'b00};
                            dmem_we_o    <= memwren_i;
                            dmem_be_o    <= byte_en(funct3_i, alu_res_i[1:0], memwren_i);
                            dmem_wdata_o <= store_lanes(funct3_i, rs2data_i);
                        end
                    end
                end

                REQ: begin
                    // Request fields are frozen until the grant is seen.
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (store_q) begin
                            state        <= IDLE;
                            wb_valid_o   <= 1'b1;
                            wb_regwren_o <= 1'b0;
                            wb_rd_o      <= rd_q;
                            wb_data_o    <= wb_value(wbsel_q, alu_q, '0, pc_q);
                            wb_pc_o      <= pc_q;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state        <= IDLE;
                        wb_valid_o   <= 1'b1;
                        wb_regwren_o <= regwren_q & (rd_q != 5'd0);
                        wb_rd_o      <= rd_q;
                        wb_data_o    <= wb_value(wbsel_q, alu_q,
                                                 load_format(funct3_q, alu_q[1:0], dmem_rdata_i),
                                                 pc_q);
                        wb_pc_o      <= pc_q;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed self-checking bench for mem_stage. Expected writeback packets are
// pushed to a scoreboard queue when an instruction is driven; a negedge
// monitor pops and compares them whenever wb_valid_o pulses. Memory-port and
// handshake behaviour is checked inline in the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] alu_res_i;
    logic [31:0] rs2data_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic        memren_i;
    logic        memwren_i;
    logic        regwren_i;
    logic [1:0]  wbsel_i;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_regwren_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_pc_o;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .pc_i          (pc_i),
        .alu_res_i     (alu_res_i),
        .rs2data_i     (rs2data_i),
        .rd_i          (rd_i),
        .funct3_i      (funct3_i),
        .memren_i      (memren_i),
        .memwren_i     (memwren_i),
        .regwren_i     (regwren_i),
        .wbsel_i       (wbsel_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_regwren_o  (wb_regwren_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .wb_pc_o       (wb_pc_o)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwren;
        logic [31:0] pc;
        logic        misalign;
    } wb_t;

    wb_t sb[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] data, input logic [4:0] rd,
                        input logic regwren, input logic [31:0] pc, input logic mis);
        wb_t e;
        e.data     = data;
        e.rd       = rd;
        e.regwren  = regwren;
        e.pc       = pc;
        e.misalign = mis;
        sb.push_back(e);
    endtask

    // Drives one instruction for a single cycle; returns just after the
    // accepting edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd,
                         input logic [2:0] f3, input logic ren, input logic wen,
                         input logic rwen, input logic [1:0] wbsel);
        check("ready_before_issue", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        pc_i       = pc;
        alu_res_i  = alu;
        rs2data_i  = rs2;
        rd_i       = rd;
        funct3_i   = f3;
        memren_i   = ren;
        memwren_i  = wen;
        regwren_i  = rwen;
        wbsel_i    = wbsel;
        tick();
        in_valid_i = 1'b0;
        memren_i   = 1'b0;
        memwren_i  = 1'b0;
    endtask

    task automatic grant();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = data;
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid_o), 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                if (!e.misalign) begin
                    check("wb_data", wb_data_o, e.data);
                end
                check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                check("wb_regwren", 32'(wb_regwren_o), 32'(e.regwren));
                check("wb_pc", wb_pc_o, e.pc);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                check("wb_misalign", 32'(misalign_o), 32'(e.misalign));
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0; pc_i = '0; alu_res_i = '0; rs2data_i = '0; rd_i = '0;
        funct3_i = '0; memren_i = 1'b0; memwren_i = 1'b0; regwren_i = 1'b0;
        wbsel_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_be", 32'(dmem_be_o), 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // ADD to rd=5, then rd=0 back to back, then PC+4 wrap
        push(32'h0000_0042, 5'd5, 1'b1, 32'h0000_0100, 1'b0);
        issue(32'h0000_0100, 32'h0000_0042, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0);
        check("add_ready", 32'(in_ready_o), 32'd1);
        push(32'h0000_0077, 5'd0, 1'b0, 32'h0000_0104, 1'b0);
        issue(32'h0000_0104, 32'h0000_0077, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd3);
        push(32'h0000_0000, 5'd1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        issue(32'hFFFF_FFFC, 32'h1234_0000, 32'h0, 5'd1, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        tick();

        // SB at offset 3, grant after 2 cycles; regwren forced off
        push(32'h0100_0003, 5'd7, 1'b0, 32'h0000_0200, 1'b0);
        issue(32'h0000_0200, 32'h0100_0003, 32'h1234_56AB, 5'd7, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check("sb_req", 32'(dmem_req_o), 32'd1);
            check("sb_we", 32'(dmem_we_o), 32'd1);
            check("sb_be", 32'(dmem_be_o), 32'b1000);
            check("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
            check("sb_addr", dmem_addr_o, 32'h0100_0000);
            check("sb_ready", 32'(in_ready_o), 32'd0);
            if (i < 2) tick();
        end
        grant();
        check("sb_req_after_gnt", 32'(dmem_req_o), 32'd0);
        tick();

        // SH at offset 2 and a LH/LHU pair at minimum latency
        push(32'h0100_0006, 5'd3, 1'b0, 32'h0000_0300, 1'b0);
        issue(32'h0000_0300, 32'h0100_0006, 32'h0000_BEEF, 5'd3, 3'd1, 1'b0, 1'b1, 1'b0, 2'd0);
        check("sh_be", 32'(dmem_be_o), 32'b1100);
        check("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
        grant();
        push(32'hFFFF_8001, 5'd4, 1'b1, 32'h0000_0304, 1'b0);
        issue(32'h0000_0304, 32'h0100_0006, 32'h0, 5'd4, 3'd1, 1'b1, 1'b0, 1'b1, 2'd1);
        check("lh_be", 32'(dmem_be_o), 32'b1111);
        check("lh_we", 32'(dmem_we_o), 32'd0);
        grant();
        respond(32'h8001_0000);
        check("lh_wb_valid", 32'(wb_valid_o), 32'd1);
        push(32'h0000_8001, 5'd4, 1'b1, 32'h0000_0308, 1'b0);
        issue(32'h0000_0308, 32'h0100_0006, 32'h0, 5'd4, 3'd5, 1'b1, 1'b0, 1'b1, 2'd1);
        grant();
        respond(32'h8001_0000);
        tick();

        // LB vs LBU at offset 2, rvalid 4 cycles after grant
        for (int k = 0; k < 2; k++) begin
            logic [2:0] f3;
            f3 = (k == 0) ? 3'd0 : 3'd4;
            push((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080, 5'd8, 1'b1, 32'h0000_0400, 1'b0);
            issue(32'h0000_0400, 32'h0100_0002, 32'h0, 5'd8, f3, 1'b1, 1'b0, 1'b1, 2'd1);
            check("lb_ready_req", 32'(in_ready_o), 32'd0);
            // rvalid while still in REQ must be ignored
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = 32'hFFFF_FFFF;
            grant();
            dmem_rvalid_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check("lb_ready_wait", 32'(in_ready_o), 32'd0);
                check("lb_no_early_wb", 32'(wb_valid_o), 32'd0);
                tick();
            end
            respond(32'h0080_0000);
            tick();
        end

        // Reset while in WAIT, then a late rvalid
        issue(32'h0000_0500, 32'h0100_0010, 32'h0, 5'd6, 3'd2, 1'b1, 1'b0, 1'b1, 2'd1);
        grant();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(in_ready_o), 32'd1);
        check("midrst_wb", 32'(wb_valid_o), 32'd0);
        tick();
        rst = 1'b0;
        respond(32'h5555_5555);
        check("late_rvalid_wb", 32'(wb_valid_o), 32'd0);
        check("late_rvalid_ready", 32'(in_ready_o), 32'd1);
        check("late_rvalid_req", 32'(dmem_req_o), 32'd0);
        tick();

        // LW at a misaligned address
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        push(32'h0, 5'd9, 1'b0, 32'h0000_0600, 1'b1);
        issue(32'h0000_0600, 32'h0100_0002, 32'h0, 5'd9, 3'd2, 1'b1, 1'b0, 1'b1, 2'd1);
        check("mis_no_req", 32'(dmem_req_o), 32'd0);
        check("mis_ready", 32'(in_ready_o), 32'd1);
        check("mis_wb_valid", 32'(wb_valid_o), 32'd1);
        tick();
        check("mis_pulse_end", 32'(misalign_o), 32'd0);
        check("mis_wb_end", 32'(wb_valid_o), 32'd0);
`else
        push(32'hCAFE_BABE, 5'd9, 1'b1, 32'h0000_0600, 1'b0);
        issue(32'h0000_0600, 32'h0100_0002, 32'h0, 5'd9, 3'd2, 1'b1, 1'b0, 1'b1, 2'd1);
        check("lw_mis_req", 32'(dmem_req_o), 32'd1);
        check("lw_mis_addr", dmem_addr_o, 32'h0100_0000);
        check("lw_mis_be", 32'(dmem_be_o), 32'b1111);
        grant();
        tick();
        respond(32'hCAFE_BABE);
`endif

        tick();
        tick();
        check("sb_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
